dot_acc_stage: RTL

Sequential accumulation stage directly downstream of the 8x8 unsigned Booth multiplier. It consumes the multiplier's 16-bit products, one per handshake beat, and sums them into a wide accumulator. When a beat marked last arrives, it presents the finished dot-product sum, term count and overflow flag on a valid/ready output. The upstream operand registers drive the combinational multiplier; this block supplies the back-pressure that paces them.

---
 rtl/mul_pkg.sv | 16 +
 rtl/sat_add.sv | 29 ++
 rtl/dot_acc_stage.sv | 108 ++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier / dot-product datapath.
//   PROD_W      : width of one unsigned product from the 8x8 multiplier
//   CNT_W       : width of the term counter
//   acc_state_t : accumulation stage FSM states
package mul_pkg;

    localparam int unsigned PROD_W = 16;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } acc_state_t;

endpackage : mul_pkg

// File: rtl/sat_add.sv
// Combinational W-bit unsigned adder with overflow detection.
//   a, b : unsigned addends
//   sum  : a+b, clamped to all-ones on carry when SAT=1, else wrapped
//   ovf  : carry out of the W-bit addition
module sat_add #(
    parameter int unsigned W   = 24,
    parameter bit          SAT = 1'b1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W:0] full;

    always_comb begin
        full = {1'b0, a} + {1'b0, b};
        ovf  = full[W];
        // A saturated accumulator stays at max: adding anything non-zero
        // carries again, adding zero leaves it unchanged.
        if (SAT && full[W]) begin
            sum = '1;
        end else begin
            sum = full[W-1:0];
        end
    end

endmodule : sat_add

// File: rtl/dot_acc_stage.sv
// Dot-product accumulation stage behind the 8x8 unsigned multiplier.
// Sums 16-bit products, one per accepted beat, and presents the finished
// sum, term count and sticky overflow flag when the beat marked last lands.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : product input handshake (in_ready low while DONE)
//   in_prod, in_last     : unsigned product, final-term marker
//   out_valid/out_ready  : result handshake (out_valid high exactly in DONE)
//   out_acc              : accumulated sum (ACC_W bits)
//   out_count            : number of terms, saturating at 255
//   out_sat              : an overflow occurred during this sum
module dot_acc_stage
    import mul_pkg::*;
#(
    parameter int unsigned ACC_W = 24,
    parameter bit          SAT   = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PROD_W-1:0]  in_prod,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_acc,
    output logic [CNT_W-1:0]   out_count,
    output logic               out_sat
);

    acc_state_t        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sat_q, sat_d;
    logic              in_ready_q, out_valid_q;

    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  add_sum;
    logic              add_ovf;
    logic              accept, take;

    // Products are unsigned; zero-extend, never sign-extend.
    assign prod_ext = {{(ACC_W-PROD_W){1'b0}}, in_prod};

    sat_add #(
        .W   (ACC_W),
        .SAT (SAT)
    ) u_sat_add (
        .a   (acc_q),
        .b   (prod_ext),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    always_comb begin
        accept  = in_valid && in_ready_q;
        take    = out_valid_q && out_ready;
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        case (state_q)
            IDLE, ACC: begin
                if (accept) begin
                    acc_d   = add_sum;
                    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                    sat_d   = sat_q | add_ovf;
                    state_d = in_last ? DONE : ACC;
                end
            end
            DONE: begin
                if (take) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so both are pure
    // functions of the current state with no path from out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            in_ready_q  <= (state_d != DONE);
            out_valid_q <= (state_d == DONE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_acc   = acc_q;
    assign out_count = cnt_q;
    assign out_sat   = sat_q;

endmodule : dot_acc_stage
